// File: rtl/adder_pipe_pkg.sv
// adder_pipe_pkg
//   Shared types and helpers for the adder_pipe unit.
//   - op_e       : lane operation select (add / subtract)
//   - TXN_CNT_W  : width of the completed-transaction counter
//   - MAX_W      : widest supported lane; lane_res_t is sized for it
//   - add_sub()  : one-lane add/subtract on width+1 bits, returns {co, c}
package adder_pipe_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  localparam int TXN_CNT_W = 16;
  localparam int MAX_W     = 32;

  // Lane result sized for the widest lane; callers keep c[WIDTH-1:0].
  typedef struct packed {
    logic             co;
    logic [MAX_W-1:0] c;
  } lane_res_t;

  // Operands must already be zero-extended to MAX_W and be < 2**width.
  // Add: carry is bit `width` of the extended sum.
  // Sub: borrow is simply a < b; the result wraps modulo 2**width.
  function automatic lane_res_t add_sub(
    input op_e              op,
    input logic [MAX_W-1:0] a,
    input logic [MAX_W-1:0] b,
    input int unsigned      width
  );
    logic [MAX_W:0]   full;
    logic [MAX_W-1:0] mask;
    lane_res_t        r;
    mask = MAX_W'((33'(1) << width) - 33'(1));
    if (op == OP_ADD) begin
      full = {1'b0, a} + {1'b0, b};
    end else begin
      full = {1'b0, a} - {1'b0, b};
    end
    r.c  = full[MAX_W-1:0] & mask;
    r.co = (op == OP_ADD) ? full[width[5:0]] : (a < b);
    return r;
  endfunction

endpackage

// File: rtl/adder_pipe_stage.sv
// adder_pipe_stage
//   One valid/ready pipeline register with a generic payload.
//   in_ready = !valid_q || out_ready, so a full stage can accept on the
//   same cycle its content moves on. Payload is held while stalled.
// Ports
//   clk        clock (posedge)
//   rst        asynchronous active-low reset
//   in_valid   upstream item valid
//   in_ready   this stage can take an item
//   in_data    upstream payload [PW-1:0]
//   out_valid  this stage holds an item
//   out_ready  downstream takes the item
//   out_data   registered payload [PW-1:0]
module adder_pipe_stage #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_data
);

  logic          valid_q, valid_d;
  logic [PW-1:0] data_q, data_d;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_valid && in_ready) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/adder_pipe.sv
// adder_pipe
//   Pipelined multi-lane add/subtract unit with valid/ready on both sides.
//   Lane arithmetic is done combinationally in front of the first register
//   stage; the STAGES register stages only forward {co, c}. Unstalled
//   latency is STAGES cycles at one item per cycle. in_ready is
//   combinational from out_ready through the stage chain (no skid buffer).
//   Build option: define ADDER_PIPE_SAT_EN for saturating results
//   (add with carry -> all ones, sub with borrow -> 0; co still reported).
// Ports
//   clk        clock (posedge)
//   rst        asynchronous active-low reset
//   in_valid   a/b/op valid
//   in_ready   unit can accept
//   op         0 = add, 1 = subtract (a - b), all lanes
//   a, b       operands, lane i at [i*WIDTH +: WIDTH]
//   out_valid  c/co valid
//   out_ready  consumer accepts
//   c          results, same packing as a/b
//   co         per-lane carry (add) or borrow (sub)
//   txn_cnt    completed output transfers, wraps
module adder_pipe
  import adder_pipe_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int LANES  = 1,
  parameter int STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   op,
  input  logic [LANES*WIDTH-1:0] a,
  input  logic [LANES*WIDTH-1:0] b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] c,
  output logic [LANES-1:0]       co,
  output logic [TXN_CNT_W-1:0]   txn_cnt
);

  localparam int PW = LANES*WIDTH + LANES;

  logic [LANES*WIDTH-1:0] c_d;
  logic [LANES-1:0]       co_d;

  // Per-lane arithmetic feeding stage 0.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      lane_res_t        res;
      logic [WIDTH-1:0] c_lane;

      always_comb begin
        res    = add_sub(op_e'(op), MAX_W'(a[gi*WIDTH +: WIDTH]),
                         MAX_W'(b[gi*WIDTH +: WIDTH]), WIDTH);
        c_lane = res.c[WIDTH-1:0];
`ifdef ADDER_PIPE_SAT_EN
        if (res.co) begin
          c_lane = (op_e'(op) == OP_SUB) ? '0 : '1;
        end
`endif
      end

      assign c_d[gi*WIDTH +: WIDTH] = c_lane;
      assign co_d[gi]               = res.co;

      // Bits above WIDTH are always zero for a narrow lane.
      if (WIDTH < MAX_W) begin : g_hi
        logic unused_hi;
        assign unused_hi = |res.c[MAX_W-1:WIDTH];
      end
    end
  endgenerate

  // Stage chain: index k is the input side of stage k, index STAGES the output.
  logic [STAGES:0] stage_valid;
  logic [STAGES:0] stage_ready;
  logic [PW-1:0]   stage_data [0:STAGES];

  assign stage_valid[0]      = in_valid;
  assign stage_data[0]       = {co_d, c_d};
  assign stage_ready[STAGES] = out_ready;
  assign in_ready            = stage_ready[0];
  assign out_valid           = stage_valid[STAGES];
  assign {co, c}             = stage_data[STAGES];

  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      adder_pipe_stage #(
        .PW(PW)
      ) u_stage (
        .clk      (clk),
        .rst      (rst),
        .in_valid (stage_valid[gi]),
        .in_ready (stage_ready[gi]),
        .in_data  (stage_data[gi]),
        .out_valid(stage_valid[gi+1]),
        .out_ready(stage_ready[gi+1]),
        .out_data (stage_data[gi+1])
      );
    end
  endgenerate

  // Completed-transfer counter; natural wrap at 2**TXN_CNT_W.
  logic [TXN_CNT_W-1:0] txn_cnt_q, txn_cnt_d;

  always_comb begin
    txn_cnt_d = txn_cnt_q;
    if (out_valid && out_ready) begin
      txn_cnt_d = txn_cnt_q + TXN_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      txn_cnt_q <= '0;
    end else begin
      txn_cnt_q <= txn_cnt_d;
    end
  end

  assign txn_cnt = txn_cnt_q;

endmodule
